// File: rtl/bp_axil_nbf_pkg.sv
// Shared types and constants for the NBF-to-AXI-Lite streamer.
// Holds the NBF command layout, opcode values and streamer FSM states.
package bp_axil_nbf_pkg;

    localparam int nbf_width_gp = 136;

    localparam logic [7:0] e_nbf_fence  = 8'hFE;
    localparam logic [7:0] e_nbf_finish = 8'hFF;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [63:0] addr;
        logic [63:0] data;
    } bp_nbf_s;

    typedef enum logic [2:0] {
        e_idle,
        e_send,
        e_addr,
        e_data,
        e_fence,
        e_drain,
        e_done
    } nbf_state_e;

endpackage

// File: rtl/bp_axil_nbf_credit_counter.sv
// Outstanding-write credit counter: up on AW, down on B.
// Ports: up_i/down_i events; count_o, full_o (== max_val_p), empty_o.
module bp_axil_nbf_credit_counter #(
    parameter int max_val_p = 16,
    parameter int width_p   = $clog2(max_val_p + 1)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_o,
    output logic               full_o,
    output logic               empty_o
);

    logic [width_p-1:0] count_q, count_d;
    logic               down_eff;

    // A response with nothing outstanding must not wrap the count.
    assign down_eff = down_i & ~empty_o;

    always_comb begin
        count_d = count_q;
        unique case ({up_i, down_eff})
            2'b10:   count_d = count_q + width_p'(1);
            2'b01:   count_d = count_q - width_p'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) count_q <= '0;
        else         count_q <= count_d;
    end

    assign count_o = count_q;
    assign full_o  = (count_q == width_p'(max_val_p));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/bsg_counter_clear_up.sv
// Clearable up-counter; clear and up in one cycle gives init+1.
// Ports: clear_i, up_i; count_o of ptr_width_lp bits.
module bsg_counter_clear_up #(
    parameter int max_val_p    = 4,
    parameter int init_val_p   = 0,
    parameter int ptr_width_lp = $clog2(max_val_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    up_i,
    output logic [ptr_width_lp-1:0] count_o
);

    logic [ptr_width_lp-1:0] count_q, count_d;

    always_comb begin
        count_d = clear_i ? ptr_width_lp'(init_val_p) : count_q;
        if (up_i) count_d = count_d + ptr_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) count_q <= ptr_width_lp'(init_val_p);
        else         count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/bp_axil_nbf_streamer.sv
// Streams NBF commands as fixed-address AXI-Lite writes, credit-bounded.
// Ports: nbf_i/v_i/ready_and_o command in; m_axil_* master; done/error.
module bp_axil_nbf_streamer
    import bp_axil_nbf_pkg::*;
#(
    parameter int          axil_addr_width_p = 64,
    parameter int          axil_data_width_p = 32,
    parameter int          credits_p         = 16,
    parameter logic [63:0] nbf_host_addr_p   = 64'h0
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  bp_nbf_s                        nbf_i,
    input  logic                           v_i,
    output logic                           ready_and_o,
    output logic [axil_addr_width_p-1:0]   m_axil_awaddr_o,
    output logic [2:0]                     m_axil_awprot_o,
    output logic                           m_axil_awvalid_o,
    input  logic                           m_axil_awready_i,
    output logic [axil_data_width_p-1:0]   m_axil_wdata_o,
    output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
    output logic                           m_axil_wvalid_o,
    input  logic                           m_axil_wready_i,
    input  logic [1:0]                     m_axil_bresp_i,
    input  logic                           m_axil_bvalid_i,
    output logic                           m_axil_bready_o,
    output logic                           done_o,
    output logic                           error_o,
    output logic [7:0]                     err_count_o
);

    localparam int dw_lp    = axil_data_width_p;
    localparam int flits_lp = (nbf_width_gp + dw_lp - 1) / dw_lp;
    localparam int fw_lp    = $clog2(flits_lp);
    localparam int slots_lp = 1 << fw_lp;
    localparam int pad_lp   = slots_lp * dw_lp - nbf_width_gp;
    localparam int cnt_w_lp = $clog2(credits_p + 1);

    localparam logic [fw_lp-1:0] last_flit_lp = fw_lp'(flits_lp - 1);

    nbf_state_e state_q, state_d, after_flit;
    bp_nbf_s    cmd_q, cmd_d;
    logic       error_q, error_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic [slots_lp-1:0][dw_lp-1:0] flit_arr;
    logic [fw_lp-1:0]    flit_cnt;
    logic [cnt_w_lp-1:0] credit_cnt;
    logic credit_full, credit_empty;
    logic aw_v, w_v, rdy, aw_hs, w_hs, b_hs;
    logic accept, last_flit, flit_done, drained;

    assign aw_hs     = aw_v & m_axil_awready_i;
    assign w_hs      = w_v & m_axil_wready_i;
    assign b_hs      = m_axil_bvalid_i;
    assign accept    = v_i & rdy;
    assign last_flit = (flit_cnt == last_flit_lp);

    assign flit_done = ((state_q == e_send) & aw_hs & w_hs)
                     | ((state_q == e_addr) & aw_hs)
                     | ((state_q == e_data) & w_hs);

    // Treat the cycle of the final B as drained so the wait ends promptly.
    assign drained = credit_empty
                   | ((credit_cnt == cnt_w_lp'(1)) & b_hs);

    // Command zero-padded at the MSB; flit 0 is the low slice.
    assign flit_arr = {{pad_lp{1'b0}}, cmd_q};

    bsg_counter_clear_up #(
        .max_val_p (flits_lp - 1),
        .init_val_p(0)
    ) flit_ctr (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(accept),
        .up_i   (flit_done & ~last_flit),
        .count_o(flit_cnt)
    );

    bp_axil_nbf_credit_counter #(
        .max_val_p(credits_p)
    ) credits (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .up_i   (aw_hs),
        .down_i (b_hs),
        .count_o(credit_cnt),
        .full_o (credit_full),
        .empty_o(credit_empty)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= e_idle;
        else         state_q <= state_d;
    end

    always_comb begin
        after_flit = e_send;
        if (last_flit)
            after_flit = (cmd_q.opcode == e_nbf_finish) ? e_drain : e_idle;
        state_d = state_q;
        unique case (state_q)
            e_idle:  if (accept)
                         state_d = (nbf_i.opcode == e_nbf_fence)
                                 ? e_fence : e_send;
            e_send:  begin
                         unique case (1'b1)
                             aw_hs & w_hs:  state_d = after_flit;
                             aw_hs & ~w_hs: state_d = e_data;
                             w_hs & ~aw_hs: state_d = e_addr;
                             default:       state_d = e_send;
                         endcase
                     end
            e_addr:  if (aw_hs) state_d = after_flit;
            e_data:  if (w_hs)  state_d = after_flit;
            e_fence: if (drained) state_d = e_idle;
            e_drain: if (drained) state_d = e_done;
            e_done:  state_d = e_done;
            default: state_d = e_idle;
        endcase
    end

    // e_addr/e_data are only reachable when credits were free, so
    // their valids need no credit gating.
    always_comb begin
        aw_v   = 1'b0;
        w_v    = 1'b0;
        rdy    = 1'b0;
        done_o = 1'b0;
        unique case (state_q)
            e_idle:  rdy    = ~reset_i;
            e_send:  begin
                         aw_v = ~credit_full;
                         w_v  = ~credit_full;
                     end
            e_addr:  aw_v   = 1'b1;
            e_data:  w_v    = 1'b1;
            e_done:  done_o = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cmd_d     = accept ? nbf_i : cmd_q;
        error_d   = error_q;
        err_cnt_d = err_cnt_q;
        if (b_hs && (m_axil_bresp_i != 2'b00)) begin
            error_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_q     <= '0;
            error_q   <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            cmd_q     <= cmd_d;
            error_q   <= error_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ready_and_o      = rdy;
    assign m_axil_awaddr_o  = nbf_host_addr_p[axil_addr_width_p-1:0];
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = aw_v;
    assign m_axil_wdata_o   = flit_arr[flit_cnt];
    assign m_axil_wstrb_o   = '1;
    assign m_axil_wvalid_o  = w_v;
    assign m_axil_bready_o  = 1'b1;
    assign error_o          = error_q;
    assign err_count_o      = err_cnt_q;

endmodule

// File: tb/tb_bp_axil_nbf_streamer.sv
// Randomized bench for bp_axil_nbf_streamer (32-bit and 64-bit builds).
// A slave model and a slicing model of the command supply expectations.
module tb_bp_axil_nbf_streamer;
    import bp_axil_nbf_pkg::*;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    bp_nbf_s     nbf;
    logic        v_i = 1'b0;
    logic        ready;
    logic [63:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;
    logic        done, error;
    logic [7:0]  err_count;

    bp_nbf_s     nbf64;
    logic        v64 = 1'b0;
    logic        ready64;
    logic [63:0] awaddr64;
    logic [2:0]  awprot64;
    logic        awvalid64;
    logic [63:0] wdata64;
    logic [7:0]  wstrb64;
    logic        wvalid64;
    logic        bready64, done64, error64;
    logic [7:0]  err_count64;

    bp_axil_nbf_streamer dut (
        .clk_i(clk), .reset_i(reset_i), .nbf_i(nbf), .v_i(v_i),
        .ready_and_o(ready), .m_axil_awaddr_o(awaddr),
        .m_axil_awprot_o(awprot), .m_axil_awvalid_o(awvalid),
        .m_axil_awready_i(awready), .m_axil_wdata_o(wdata),
        .m_axil_wstrb_o(wstrb), .m_axil_wvalid_o(wvalid),
        .m_axil_wready_i(wready), .m_axil_bresp_i(bresp),
        .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
        .done_o(done), .error_o(error), .err_count_o(err_count)
    );

    bp_axil_nbf_streamer #(.axil_data_width_p(64)) dut64 (
        .clk_i(clk), .reset_i(reset_i), .nbf_i(nbf64), .v_i(v64),
        .ready_and_o(ready64), .m_axil_awaddr_o(awaddr64),
        .m_axil_awprot_o(awprot64), .m_axil_awvalid_o(awvalid64),
        .m_axil_awready_i(1'b1), .m_axil_wdata_o(wdata64),
        .m_axil_wstrb_o(wstrb64), .m_axil_wvalid_o(wvalid64),
        .m_axil_wready_i(1'b1), .m_axil_bresp_i(2'b00),
        .m_axil_bvalid_i(1'b0), .m_axil_bready_o(bready64),
        .done_o(done64), .error_o(error64), .err_count_o(err_count64)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    logic [63:0] exp64_q[$];
    int pend = 0;
    int exp_err = 0;
    int aw_total = 0;
    int w_total = 0;
    int skew_cnt = 0;
    int aw_pct = 100;
    int w_pct = 100;
    int b_pct = 100;
    int err_pct = 0;
    int aw_delay = 0;
    int aw_wait = 0;
    bit b_en = 1'b1;
    bit release_one = 1'b0;

    // AXI-Lite slave: drive readies at negedge, log handshakes at +1.
    initial begin
        logic [31:0] e;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                awready = 1'b0; wready = 1'b0;
                bvalid = 1'b0; bresp = 2'b00; aw_wait = 0;
                continue;
            end
            if (aw_delay > 0) begin
                awready = awvalid && (aw_wait >= aw_delay);
                if (awvalid && !awready) aw_wait++;
            end else begin
                awready = ($urandom_range(99) < aw_pct);
            end
            wready = ($urandom_range(99) < w_pct);
            if (release_one) begin
                bvalid = 1'b1;
                release_one = 1'b0;
            end else begin
                bvalid = b_en && (pend > 0) && ($urandom_range(99) < b_pct);
            end
            bresp = (bvalid && $urandom_range(99) < err_pct) ? 2'b10 : 2'b00;
            #1;
            if (awvalid && awready) begin
                aw_total++; pend++; aw_wait = 0; n_vec++;
                if (awaddr !== 64'h0 || awprot !== 3'b000) begin
                    n_err++;
                    $display("FAIL aw_addr: got %h/%h want 0/0", awaddr, awprot);
                end
            end
            if (wvalid && wready) begin
                w_total++; n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL w_extra: got %h want no write", wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (wdata !== e || wstrb !== 4'hF) begin
                        n_err++;
                        $display("FAIL w_data: got %h/%h want %h/f", wdata, wstrb, e);
                    end
                end
            end
            if (awvalid && !wvalid) skew_cnt++;
            if (bvalid) begin
                if (pend > 0) pend--;
                if (bresp != 2'b00) exp_err++;
            end
        end
    end

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_i && wvalid64) begin
                n_vec++;
                if (exp64_q.size() == 0) begin
                    n_err++;
                    $display("FAIL w64_extra: got %h want no write", wdata64);
                end else begin
                    e = exp64_q.pop_front();
                    if (wdata64 !== e || wstrb64 !== 8'hFF) begin
                        n_err++;
                        $display("FAIL w64_data: got %h want %h", wdata64, e);
                    end
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic send_cmd(input logic [7:0] op, input logic [63:0] a,
                            input logic [63:0] d);
        logic [255:0] v;
        int t;
        @(negedge clk);
        nbf = '{op, a, d};
        v_i = 1'b1;
        t = 0;
        #2;
        while (!ready && t < 400) begin
            @(negedge clk); #2; t++;
        end
        n_vec++;
        if (!ready) begin
            n_err++;
            $display("FAIL cmd_accept: got ready 0 want 1 op %h", op);
            v_i = 1'b0;
            return;
        end
        v = {120'b0, op, a, d};
        if (op != e_nbf_fence)
            for (int k = 0; k < 5; k++) exp_q.push_back(v[k*32 +: 32]);
        @(posedge clk);
        #1 v_i = 1'b0;
    endtask

    task automatic send_rand();
        send_cmd(8'($urandom_range(253)), {$urandom, $urandom},
                 {$urandom, $urandom});
    endtask

    task automatic wait_quiet();
        int t = 0;
        b_en = 1'b1;
        while (!(exp_q.size() == 0 && pend == 0 && ready) && t < 3000) begin
            @(negedge clk); #2; t++;
        end
        n_vec++;
        if (!(exp_q.size() == 0 && pend == 0 && ready)) begin
            n_err++;
            $display("FAIL quiet: got q=%0d pend=%0d rdy=%b want 0 0 1",
                     exp_q.size(), pend, ready);
        end
    endtask

    task automatic wait_pend(input int n);
        int t = 0;
        while (pend != n && t < 400) begin
            @(negedge clk); #2; t++;
        end
        n_vec++;
        if (pend != n) begin
            n_err++;
            $display("FAIL pend_wait: got %0d want %0d", pend, n);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_vec++;
        if ({ready, awvalid, wvalid, done, error} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {ready, awvalid, wvalid, done, error});
        end
        n_vec++;
        if (err_count !== 8'd0 || bready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_err: got %0d/%b want 0/1", err_count, bready);
        end
        reset_i = 1'b0;
        @(negedge clk); #2;
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_rdy: got %b want 1", ready);
        end
    endtask

    task automatic test_single();
        int w0 = w_total;
        aw_pct = 100; w_pct = 100; b_pct = 100; b_en = 1'b1;
        send_cmd(8'h08, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567);
        for (int i = 1; i <= 5; i++) begin
            n_vec++;
            if ({awvalid, wvalid, ready, done} !== 4'b1100) begin
                n_err++;
                $display("FAIL single_lat: got %b want 1100 at t+%0d",
                         {awvalid, wvalid, ready, done}, i);
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (ready !== 1'b1 || awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL single_idle: got %b%b want 10", ready, awvalid);
        end
        wait_quiet();
        n_vec++;
        if (w_total - w0 != 5) begin
            n_err++;
            $display("FAIL single_cnt: got %0d want 5", w_total - w0);
        end
    endtask

    task automatic test_width64();
        logic [255:0] v;
        int t;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) nbf64 = '{8'h08, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567};
            else nbf64 = '{8'($urandom_range(253)), {$urandom, $urandom},
                           {$urandom, $urandom}};
            v64 = 1'b1;
            t = 0;
            #2;
            while (!ready64 && t < 50) begin
                @(negedge clk); #2; t++;
            end
            v = {120'b0, nbf64};
            for (int k = 0; k < 3; k++) exp64_q.push_back(v[k*64 +: 64]);
            @(posedge clk);
            #1 v64 = 1'b0;
        end
        repeat (8) @(negedge clk);
        #2;
        n_vec++;
        if (exp64_q.size() != 0 || done64 !== 1'b0) begin
            n_err++;
            $display("FAIL w64_drain: got %0d left want 0", exp64_q.size());
        end
    endtask

    task automatic test_random();
        int w0 = w_total;
        b_pct = 50;
        for (int c = 0; c < 20; c++) begin
            aw_pct = $urandom_range(100, 30);
            w_pct = $urandom_range(100, 30);
            send_rand();
        end
        wait_quiet();
        aw_pct = 100; w_pct = 100; b_pct = 100;
        n_vec++;
        if (w_total - w0 != 100) begin
            n_err++;
            $display("FAIL random_cnt: got %0d want 100", w_total - w0);
        end
    endtask

    task automatic test_backpressure();
        int a0;
        wait_quiet();
        a0 = aw_total;
        b_en = 1'b0;
        for (int c = 0; c < 4; c++) send_rand();
        repeat (8) @(negedge clk);
        #2;
        n_vec++;
        if (aw_total - a0 != 16 || awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: got %0d/%b want 16/0", aw_total - a0, awvalid);
        end
        @(posedge clk);
        release_one = 1'b1;
        @(negedge clk); #2;
        n_vec++;
        if (awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_hold: got %b want 0", awvalid);
        end
        @(negedge clk); #2;
        n_vec++;
        if (awvalid !== 1'b1) begin
            n_err++;
            $display("FAIL bp_release: got %b want 1", awvalid);
        end
        @(negedge clk); #2;
        n_vec++;
        if (awvalid !== 1'b0 || aw_total - a0 != 17) begin
            n_err++;
            $display("FAIL bp_refull: got %b/%0d want 0/17", awvalid, aw_total - a0);
        end
        wait_quiet();
    endtask

    task automatic test_skew();
        int w0, s0;
        wait_quiet();
        w0 = w_total;
        s0 = skew_cnt;
        aw_delay = 3;
        send_cmd(8'h08, 64'h8000_0000, 64'hDEAD_BEEF_0123_4567);
        send_rand();
        wait_quiet();
        aw_delay = 0;
        n_vec++;
        if (w_total - w0 != 10) begin
            n_err++;
            $display("FAIL skew_cnt: got %0d want 10", w_total - w0);
        end
        n_vec++;
        if (skew_cnt - s0 < 5) begin
            n_err++;
            $display("FAIL skew_addr: got %0d want >=5", skew_cnt - s0);
        end
    endtask

    task automatic test_fence_finish();
        wait_quiet();
        b_en = 1'b0;
        send_rand();
        wait_pend(5);
        send_cmd(e_nbf_fence, 64'h0, 64'h0);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            release_one = 1'b1;
            @(negedge clk); #2;
            n_vec++;
            if (ready !== 1'b0) begin
                n_err++;
                $display("FAIL fence_hold: got %b want 0 (b %0d)", ready, k);
            end
            @(negedge clk); #2;
            n_vec++;
            if (ready !== (k == 5)) begin
                n_err++;
                $display("FAIL fence_rel: got %b want %b (b %0d)", ready, k == 5, k);
            end
        end
        send_cmd(e_nbf_finish, {$urandom, $urandom}, {$urandom, $urandom});
        wait_pend(5);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            release_one = 1'b1;
            @(negedge clk); #2;
            n_vec++;
            if (done !== 1'b0) begin
                n_err++;
                $display("FAIL drain_hold: got %b want 0 (b %0d)", done, k);
            end
            @(negedge clk); #2;
            n_vec++;
            if (done !== (k == 5)) begin
                n_err++;
                $display("FAIL drain_done: got %b want %b (b %0d)", done, k == 5, k);
            end
        end
        repeat (3) @(negedge clk);
        #2;
        n_vec++;
        if (done !== 1'b1 || ready !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL done_sticky: got %b%b want 10", done, ready);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset_i = 1'b1;
        #4;
        exp_q.delete(); pend = 0; exp_err = 0;
        @(negedge clk);
        reset_i = 1'b0;
        b_en = 1'b1;
    endtask

    task automatic test_error_reset();
        int want;
        pulse_reset();
        @(negedge clk); #2;
        n_vec++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_from_done: got %b%b want 01", done, ready);
        end
        @(posedge clk);
        release_one = 1'b1;
        err_pct = 100;
        @(negedge clk); #2;
        err_pct = 0;
        @(negedge clk); #2;
        n_vec++;
        if (error !== 1'b1 || err_count !== 8'd1) begin
            n_err++;
            $display("FAIL stray_b: got %b/%0d want 1/1", error, err_count);
        end
        send_rand();
        send_cmd(e_nbf_fence, 64'h0, 64'h0);
        wait_quiet();
        err_pct = 40; b_pct = 60;
        for (int c = 0; c < 6; c++) send_rand();
        wait_quiet();
        n_vec++;
        if (error !== (exp_err > 0) || err_count !== 8'(exp_err)) begin
            n_err++;
            $display("FAIL err_count: got %b/%0d want %b/%0d",
                     error, err_count, exp_err > 0, exp_err);
        end
        err_pct = 100; b_pct = 100;
        for (int c = 0; c < 52; c++) send_rand();
        wait_quiet();
        err_pct = 0;
        want = (exp_err > 255) ? 255 : exp_err;
        n_vec++;
        if (err_count !== 8'(want) || error !== 1'b1) begin
            n_err++;
            $display("FAIL err_sat: got %0d want %0d", err_count, want);
        end
        aw_pct = 0; w_pct = 0;
        send_rand();
        @(negedge clk);
        #3 reset_i = 1'b1;
        #1;
        exp_q.delete(); pend = 0; exp_err = 0;
        n_vec++;
        if ({awvalid, wvalid, ready, done, error} !== 5'b0 || err_count !== 8'd0) begin
            n_err++;
            $display("FAIL mid_reset: got %b/%0d want 00000/0",
                     {awvalid, wvalid, ready, done, error}, err_count);
        end
        @(negedge clk);
        reset_i = 1'b0;
        aw_pct = 100; w_pct = 100;
        send_rand();
        wait_quiet();
        n_vec++;
        if (error !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset: got %b%b want 00", error, done);
        end
    endtask

    initial begin
        nbf = '0;
        nbf64 = '0;
        test_reset();
        test_single();
        test_width64();
        test_random();
        test_backpressure();
        test_skew();
        test_fence_finish();
        test_error_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
